// File: rtl/rtc_bus_responder_pkg.sv
// Shared types and constants for the RTC multiplexed-bus responder and its controller.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_LATCH,
    A_HOLD,
    D_WAIT,
    D_WR,
    D_RD
  } state_e;

  localparam int DEPTH_DEFAULT = 128;

  localparam logic [7:0] RTC_TIME_LO = 8'h21;
  localparam logic [7:0] RTC_TIME_HI = 8'h26;
  localparam logic [7:0] RTC_CTRL_LO = 8'h41;
  localparam logic [7:0] RTC_CTRL_HI = 8'h43;

  // True for the time/date and control register windows of the emulated RTC.
  function automatic logic is_time_reg(input logic [7:0] addr);
    return ((addr >= RTC_TIME_LO) && (addr <= RTC_TIME_HI)) ||
           ((addr >= RTC_CTRL_LO) && (addr <= RTC_CTRL_HI));
  endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Active-low CS/AD/RD/WR multiplexed bus plus responder status outputs.
interface rtc_bus_responder_if;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] addr_q;
  logic       wr_done;
  logic       rd_done;
  logic       proto_err;

  modport master (
    output CS, AD, RD, WR, data_in,
    input  data_out, data_oe, addr_q, wr_done, rd_done, proto_err
  );

  modport slave (
    input  CS, AD, RD, WR, data_in,
    output data_out, data_oe, addr_q, wr_done, rd_done, proto_err
  );
endinterface

// File: rtl/rtc_bus_responder_regfile.sv
// DEPTH x 8 register file: synchronous write, combinational read, cleared on reset.
// Out-of-range writes are dropped and out-of-range reads return 0x00.
module rtc_regfile
  import rtc_bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];
  logic       wr_hit;
  logic       rd_hit;

  assign wr_hit = we && (int'(waddr) < DEPTH);
  assign rd_hit = (int'(raddr) < DEPTH);

  // Storage array: clear everything on reset, otherwise take in-range writes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_hit) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = rd_hit ? mem_q[raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in: decodes the two-phase multiplexed bus and serves a register file.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for AD low with CS high (start of address phase)
// A_SETUP | address phase opened, waiting for the CS/WR latch strobe
// A_LATCH | latch strobe active, addr_q follows data_in
// A_HOLD  | address latched, waiting for AD high (data phase)
// D_WAIT  | data phase, waiting for a CS+WR or CS+RD strobe
// D_WR    | write strobe active, capturing data_in until strobe end
// D_RD    | read strobe active, driving registered read data
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_responder_if.slave bus
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       wr_done_q, wr_done_d;
  logic       rd_done_q, rd_done_d;
  logic       proto_err_q, proto_err_d;
  logic       mem_we;
  logic [7:0] mem_rdata;

  rtc_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  // Next-state, capture and pulse decode; overlapping RD/WR aborts from any state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_out_d  = 8'h00;
    data_oe_d   = 1'b0;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    proto_err_d = 1'b0;
    mem_we      = 1'b0;

    if (!bus.RD && !bus.WR) begin
      proto_err_d = 1'b1;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.CS) begin
            proto_err_d = 1'b1;
          end else if (!bus.AD) begin
            state_d = A_SETUP;
          end
        end
        A_SETUP: begin
          if (!bus.CS && !bus.WR) begin
            state_d = A_LATCH;
            addr_d  = bus.data_in;
          end else if (bus.AD) begin
            state_d = IDLE;
          end
        end
        A_LATCH: begin
          addr_d = bus.data_in;
          if (bus.CS) begin
            state_d = A_HOLD;
          end else if (bus.AD) begin
            proto_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
        A_HOLD: begin
          if (bus.AD) begin
            state_d = D_WAIT;
          end
        end
        D_WAIT: begin
          if (!bus.CS && !bus.WR && bus.RD) begin
            state_d = D_WR;
            wdata_d = bus.data_in;
          end else if (!bus.CS && !bus.RD && bus.WR) begin
            state_d = D_RD;
          end else if (!bus.AD) begin
            state_d = A_SETUP;
          end
        end
        D_WR: begin
          if (bus.CS || bus.WR) begin
            mem_we    = 1'b1;
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            wdata_d = bus.data_in;
          end
        end
        D_RD: begin
          if (bus.CS || bus.RD) begin
            rd_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            data_oe_d  = 1'b1;
            data_out_d = mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.addr_q    = addr_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed scenarios plus randomized traffic against
// a flat byte-array model of the RTC register space.
`timescale 1ns/1ps
module tb_rtc_bus_responder;
  import rtc_bus_pkg::*;

  localparam int DEPTH = DEPTH_DEFAULT;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rtc_bus_responder_if bus ();

  rtc_bus_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int wr_seen = 0, rd_seen = 0, perr_seen = 0;
  int wr_exp = 0, rd_exp = 0, perr_exp = 0;
  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Count every cycle each pulse output is high.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_done === 1'b1) wr_seen++;
      if (bus.rd_done === 1'b1) rd_seen++;
      if (bus.proto_err === 1'b1) perr_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.CS = 1'b1;
    bus.AD = 1'b1;
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    bus.data_in = 8'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    return (int'(a) < DEPTH) ? ref_mem[a] : 8'h00;
  endfunction

  // Address phase; leaves the responder in the data-phase wait state.
  task automatic addr_phase(input logic [7:0] a, input bit skip_open);
    if (!skip_open) begin
      bus.AD = 1'b0; bus.CS = 1'b1; bus.WR = 1'b1; bus.RD = 1'b1;
      tick();
    end
    bus.AD = 1'b0; bus.CS = 1'b0; bus.WR = 1'b0; bus.data_in = a;
    tick();
    bus.CS = 1'b1; bus.WR = 1'b1;
    tick();
    chk("addr_latch", bus.addr_q, a);
    bus.AD = 1'b1;
    tick();
  endtask

  // Data-phase write with WR held low for n cycles; only the last byte counts.
  task automatic data_write(input logic [7:0] a, input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      bus.CS = 1'b0; bus.WR = 1'b0;
      bus.data_in = (k == n - 1) ? d : 8'($urandom);
      tick();
    end
    bus.CS = 1'b1; bus.WR = 1'b1; bus.data_in = ~d;
    tick();
    chk("wr_done_pulse", bus.wr_done, 1);
    wr_exp++;
    if (int'(a) < DEPTH) ref_mem[a] = d;
  endtask

  // Data-phase read with RD held low for hold (>=2) cycles.
  task automatic data_read(input logic [7:0] a, input int hold);
    logic [7:0] exp;
    exp = model_read(a);
    bus.CS = 1'b0; bus.RD = 1'b0;
    tick();
    chk("rd_oe_first_edge", bus.data_oe, 0);
    chk("rd_data_first_edge", bus.data_out, 0);
    for (int k = 2; k <= hold; k++) begin
      tick();
      chk("rd_oe", bus.data_oe, 1);
      chk("rd_data", bus.data_out, exp);
    end
    bus.CS = 1'b1; bus.RD = 1'b1;
    tick();
    chk("rd_done_pulse", bus.rd_done, 1);
    chk("rd_oe_release", bus.data_oe, 0);
    chk("rd_data_release", bus.data_out, 0);
    rd_exp++;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int n);
    addr_phase(a, 1'b0);
    data_write(a, d, n);
  endtask

  task automatic do_read(input logic [7:0] a, input int hold);
    addr_phase(a, 1'b0);
    data_read(a, hold);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus_idle();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [7:0] a, d;
    int wr0, rd0;

    clear_model();
    reset = 1'b1;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_oe", bus.data_oe, 0);
    chk("rst_addr_q", bus.addr_q, 0);
    chk("rst_wr_done", bus.wr_done, 0);
    chk("rst_rd_done", bus.rd_done, 0);
    chk("rst_proto_err", bus.proto_err, 0);
    do_read(8'h00, 3);
    do_read(8'h7F, 3);

    // Basic write then read of a time register.
    do_write(8'h21, 8'h59, 1);
    bus_idle(); tick();
    do_read(8'h21, 6);

    // Unmapped write must not alias onto a mapped register.
    do_write(8'h90, 8'hAA, 2);
    do_read(8'h90, 4);
    do_read(8'h10, 3);

    // RD and WR overlapping in the data phase.
    addr_phase(8'h21, 1'b0);
    bus.CS = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0; bus.data_in = 8'hEE;
    tick();
    chk("overlap_proto_err", bus.proto_err, 1);
    chk("overlap_no_wr_done", bus.wr_done, 0);
    perr_exp++;
    bus_idle();
    tick();
    chk("overlap_pulse_width", bus.proto_err, 0);
    do_read(8'h21, 3);

    // Reset during a read drops data_oe on the next edge.
    do_write(8'h22, 8'h5A, 1);
    addr_phase(8'h22, 1'b0);
    bus.CS = 1'b0; bus.RD = 1'b0;
    tick();
    tick();
    chk("pre_reset_oe", bus.data_oe, 1);
    chk("pre_reset_data", bus.data_out, 8'h5A);
    apply_reset();
    chk("reset_rd_oe", bus.data_oe, 0);
    chk("reset_rd_data", bus.data_out, 0);
    chk("reset_rd_no_rd_done", bus.rd_done, 0);

    // Reset during a write aborts it and clears the register file.
    do_write(8'h21, 8'h33, 1);
    addr_phase(8'h42, 1'b0);
    bus.CS = 1'b0; bus.WR = 1'b0; bus.data_in = 8'h07;
    tick();
    tick();
    apply_reset();
    chk("reset_wr_oe", bus.data_oe, 0);
    chk("reset_wr_no_wr_done", bus.wr_done, 0);
    chk("reset_wr_addr_q", bus.addr_q, 0);
    tick();
    do_read(8'h42, 3);
    do_read(8'h21, 3);

    // Abandoned address phase: AD drops again before any data strobe.
    addr_phase(8'h41, 1'b0);
    bus.AD = 1'b0; bus.CS = 1'b1;
    tick();
    addr_phase(8'h43, 1'b1);
    data_write(8'h43, 8'h15, 1);
    do_read(8'h43, 3);
    do_read(8'h41, 3);

    // Back-to-back writes and reads with no idle cycles.
    bus_idle(); tick();
    wr0 = wr_seen;
    rd0 = rd_seen;
    for (int i = 0; i < 6; i++) do_write(8'(8'h21 + i), 8'(i + 1), 1);
    for (int i = 0; i < 6; i++) do_read(8'(8'h21 + i), 2);
    bus_idle(); tick(); tick();
    chk("b2b_wr_pulses", 32'(wr_seen - wr0), 6);
    chk("b2b_rd_pulses", 32'(rd_seen - rd0), 6);

    // Randomized traffic around mapped registers and the DEPTH boundary.
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: a = 8'($urandom_range(8'h21, 8'h26));
        1: a = 8'($urandom_range(8'h7C, 8'h83));
        2: a = 8'($urandom_range(8'h41, 8'h43));
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, d, $urandom_range(1, 3));
      else do_read(a, $urandom_range(2, 6));
      if ($urandom_range(0, 2) == 0) begin
        bus_idle();
        repeat ($urandom_range(1, 2)) tick();
      end
    end

    bus_idle();
    tick(); tick();
    chk("total_wr_done", wr_seen, wr_exp);
    chk("total_rd_done", rd_seen, rd_exp);
    chk("total_proto_err", perr_seen, perr_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Synthesizable responder for the multiplexed address/data bus that our RTC controller drives with its active-low CS, AD, RD and WR strobes. It decodes the two-phase transaction: an address phase with AD low and CS/WR pulsed, then a data phase with AD high and CS pulsed with either WR or RD. It writes into or reads from an internal 8-bit register file. It serves as an RTC chip stand-in for on-board loopback and as the bus-level responder in controller benches.

## Interface
- DEPTH, 128: number of 8-bit registers. Addresses at or above DEPTH are unmapped.
- clk  in  1  single system clock. All inputs are sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- CS  in  1  chip select, active low.
- AD  in  1  address/data phase select. 0 = address phase, 1 = data phase.
- RD  in  1  read strobe, active low.
- WR  in  1  write/latch strobe, active low.
- data_in  in  8  bus value from the controller.
- data_out  out  8  read data. 0x00 whenever data_oe = 0.
- data_oe  out  1  high while the responder drives read data.
- addr_q  out  8  last latched address.
- wr_done  out  1  one-cycle pulse when a write commits.
- rd_done  out  1  one-cycle pulse when a read strobe ends.
- proto_err  out  1  one-cycle pulse on a protocol violation.

## Operation
- FSM states: IDLE, A_SETUP, A_LATCH, A_HOLD, D_WAIT, D_WR, D_RD.
- IDLE: AD=0 with CS=1 → A_SETUP. CS=0 in IDLE → proto_err, stay in IDLE.
- A_SETUP:
  - CS=0 and WR=0 → A_LATCH, and addr_q ← data_in.
  - AD=1 → IDLE.
- A_LATCH:
  - Re-latch addr_q ← data_in every cycle.
  - CS=1 → A_HOLD.
  - AD=1 while CS=0 → proto_err, IDLE.
- A_HOLD: AD=1 → D_WAIT.
- D_WAIT:
  - CS=0 and WR=0 and RD=1 → D_WR; capture data_in.
  - CS=0 and RD=0 and WR=1 → D_RD.
  - AD=0 → A_SETUP. This is a new transaction; the old address is discarded.
- D_WR:
  - Re-capture data_in every cycle.
  - On the first cycle with CS=1 or WR=1, commit the last captured byte to mem[addr_q], pulse wr_done, → IDLE.
- D_RD:
  - data_oe=1; data_out = mem[addr_q], registered.
  - On the first cycle with CS=1 or RD=1: data_oe←0, pulse rd_done, → IDLE.
- RD=0 and WR=0 together in any state → proto_err, no commit, → IDLE.
- Unmapped address (addr_q ≥ DEPTH):
  - Write: wr_done still pulses, memory is unchanged.
  - Read: returns 0x00.
- Register file:
  - Single write port, one combinational read port.
  - Every register holds its value outside committed writes.
  - Time/date registers 0x21–0x26 and 0x41–0x43 are ordinary read/write storage here.

## Timing
- Reset values:
  - State IDLE; all registers 0x00.
  - data_out=0x00, data_oe=0, addr_q=0x00.
  - wr_done=rd_done=proto_err=0.
- Reset mid-transaction aborts it with no commit. data_oe drops on the next edge.
- Read latency: data_oe and data_out are valid on the 2nd rising edge after RD falls: one edge to enter D_RD, one edge to register. The controller holds RD low for 6 cycles, so its sampling is safe.
- Write commit: on the edge where the strobe end is sampled. The new value is readable from the next cycle.
- Pulse timing: each pulse is exactly 1 cycle, asserted the cycle after the condition is sampled.
- Back-to-back transactions: a new AD fall is accepted in the cycle right after returning to IDLE.
- There is no minimum strobe width. A 1-cycle CS/WR pulse in the data phase still commits.

## Structure
- Package rtc_bus_pkg holds:
  - FSM state enum.
  - DEPTH default.
  - Address constants RTC_TIME_LO=0x21, RTC_TIME_HI=0x26, RTC_CTRL_LO=0x41, RTC_CTRL_HI=0x43.
  - A helper function is_time_reg(addr).
- The controller shares rtc_bus_pkg.
- Sub-module rtc_regfile:
  - DEPTH×8 synchronous-write, asynchronous-read array.
  - Synchronous clear on reset.
  - Write enable gated by an address-range check.

## Test plan
- Write: address phase latching 0x21, data phase with WR and data_in=0x59.
  - wr_done pulses once; mem[0x21]=0x59.
  - Read of 0x21 returns data_out=0x59 with data_oe=1 from the 2nd edge after RD falls.
- Unmapped: write 0xAA to 0x90.
  - wr_done pulses, no memory change.
  - Read of 0x90 returns 0x00.
- Overlap: RD and WR both low in the data phase → proto_err pulse, mem[addr_q] unchanged, FSM in IDLE.
- Reset mid-write: assert reset during D_WR to 0x42 with data 0x07 → no commit, data_oe=0, all registers 0x00.
- Abandoned address: address phase 0x41, then AD returns low before any data strobe.
  - New address 0x43 latched; write 0x15.
  - mem[0x43]=0x15, mem[0x41]=0x00.
- Back-to-back: writes of 0x01..0x06 to 0x21..0x26 with zero idle cycles, then reads of all six → each returns its written value; 6 wr_done and 6 rd_done pulses.
